window_scanner: RTL and testbench
=================================

// Module: window_scanner
// PURPOSE
//  Downstream of the zero-padding stage. Captures one padded feature map (CH x H x W) in a
//  single load, then streams every KxK stride-1 window, one window per cycle, under a
//  valid/ready handshake. Output feeds the 3x3 convolution MAC array. A 32x5x6 map yields
//  3x4 = 12 windows, restoring the unpadded 3x4 output size.
// PARAMETERS
//  DL   `data_len  bit width of one map element
//  CH   32         channels
//  H    5          padded map height
//  W    6          padded map width
//  K    3          window size; OH=H-K+1, OW=W-K+1
// PORTS
//  clk        in   1             clock, all logic on posedge
//  rst_n      in   1             synchronous active-low reset
//  load       in   1             capture d this cycle (honoured only when ready=1)
//  d          in   CH*H*W*DL     padded map; element (c,r,x) at d[((c*H*W+r*W+x)*DL)+:DL]
//  ready      out  1             block idle, load will be accepted
//  out_valid  out  1             out_win holds a valid window
//  out_ready  in   1             consumer accepts window this cycle
//  out_win    out  CH*K*K*DL     window; (c,kr,kc) at [((c*K*K+kr*K+kc)*DL)+:DL]
//  out_row    out  clog2(OH)     window top row (max(1,..) bits)
//  out_col    out  clog2(OW)     window left column
//  out_last   out  1             out_valid on final window (row OH-1, col OW-1)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state IDLE, ready=1, out_valid=0, out_last=0,
//    row=col=0, map buffer cleared, so out_win=0. Reset wins over load/handshake.
//  - States: IDLE, SCAN.
//    IDLE: ready=1, out_valid=0. load=1 -> buffer<=d, row=col=0, go SCAN.
//    SCAN: ready=0, out_valid=1. load ignored (buffer untouched).
//      Handshake (out_valid & out_ready) advances: col+1; if col==OW-1 then col=0,row+1.
//      Handshake on last window -> IDLE (ready=1 next cycle). No advance without out_ready.
//  - Latency: out_valid rises the cycle after the accepting load edge; with out_ready=1
//    constantly, OH*OW windows on consecutive cycles, then one IDLE cycle before next load
//    is accepted (load in the final-handshake cycle is ignored).
//  - out_win[c,kr,kc] = buffer[c, row+kr, col+kc]; pure mux of registered buffer and
//    counters, so out_win/out_row/out_col/out_last hold stable while out_valid & !out_ready.
//  - out_last = out_valid & row==OH-1 & col==OW-1.
//  - Data passes unaltered; no arithmetic, no sign handling.
//  - Reset mid-SCAN aborts the scan; the next accepted load restarts at (0,0).
// TESTING
//  1 Reset: rst_n=0 one cycle -> ready=1, out_valid=0, out_last=0, out_win=0.
//  2 Load d with element value = flat index mod 2^DL, out_ready=1 -> out_valid next cycle;
//    12 windows on consecutive cycles; ch0 at (0,0)={0,1,2,6,7,8,12,13,14};
//    ch0 at (2,3)={15,16,17,21,22,23,27,28,29} with out_last=1; ready=1 the cycle after.
//  3 Backpressure: out_ready=0 for 5 cycles at (1,2) -> out_win/out_row=1/out_col=2 stable,
//    resumes at (1,3) then (2,0) once out_ready=1; total still 12 windows.
//  4 load=1 with new d during SCAN -> ready=0, ignored; remaining windows come from first map.
//  5 rst_n=0 after 5th handshake -> next cycle out_valid=0, ready=1; new load starts at (0,0).
//  6 d = zero-padded all-ones 3x4 interior -> every channel at (0,0) = {0,0,0,0,1,1,0,1,1},
//    at (1,1) = all ones.

Source files
------------

// File: rtl/window_scanner_if.sv
// Window scanner bus: map load handshake on the input side,
// window stream handshake on the output side.
interface window_scanner_if #(
  parameter int CH = 32,
  parameter int H  = 5,
  parameter int W  = 6,
  parameter int K  = 3,
  parameter int DL = 8
);
  localparam int OH = H - K + 1;
  localparam int OW = W - K + 1;
  localparam int RW = (OH > 1) ? $clog2(OH) : 1;
  localparam int CW = (OW > 1) ? $clog2(OW) : 1;

  logic                   load;
  logic [CH*H*W*DL-1:0]   d;
  logic                   ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [CH*K*K*DL-1:0]   out_win;
  logic [RW-1:0]          out_row;
  logic [CW-1:0]          out_col;
  logic                   out_last;

  modport master (
    output load, d, out_ready,
    input  ready, out_valid, out_win,
    input  out_row, out_col, out_last
  );

  modport slave (
    input  load, d, out_ready,
    output ready, out_valid, out_win,
    output out_row, out_col, out_last
  );
endinterface

// File: rtl/window_scanner.sv
// Captures one padded feature map and streams every KxK
// stride-1 window, one per accepted handshake.
module window_scanner #(
  parameter int CH = 32,
  parameter int H  = 5,
  parameter int W  = 6,
  parameter int K  = 3,
  parameter int DL = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  window_scanner_if.slave  bus
);
  localparam int OH = H - K + 1;
  localparam int OW = W - K + 1;
  localparam int RW = (OH > 1) ? $clog2(OH) : 1;
  localparam int CW = (OW > 1) ? $clog2(OW) : 1;
  localparam int MW = CH * H * W * DL;
  localparam int WW = CH * K * K * DL;
  localparam logic [RW-1:0] ROW_LAST = RW'(OH - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(OW - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state, state_nxt;
  logic [RW-1:0] row, row_nxt;
  logic [CW-1:0] col, col_nxt;
  logic [MW-1:0] map_q;
  logic [WW-1:0] win;
  logic          take;
  logic          at_end;

  assign at_end = (row == ROW_LAST) && (col == COL_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
      map_q <= '0;
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
      col   <= col_nxt;
      if (take)
        map_q <= bus.d;
    end
  end

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    col_nxt   = col;
    take      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.load) begin
          take      = 1'b1;
          row_nxt   = '0;
          col_nxt   = '0;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (bus.out_ready) begin
          if (at_end) begin
            state_nxt = IDLE;
            row_nxt   = '0;
            col_nxt   = '0;
          end else if (col == COL_LAST) begin
            col_nxt = '0;
            row_nxt = row + 1'b1;
          end else begin
            col_nxt = col + 1'b1;
          end
        end
      end
    endcase
  end

  // Window is a pure mux of the held map, so it stays put under backpressure
  always_comb begin
    win = '0;
    for (int c = 0; c < CH; c++)
      for (int kr = 0; kr < K; kr++)
        for (int kc = 0; kc < K; kc++)
          win[((c*K*K + kr*K + kc)*DL) +: DL] =
            map_q[((c*H*W + (int'(row) + kr)*W
                    + int'(col) + kc)*DL) +: DL];
  end

  assign bus.ready     = (state == IDLE);
  assign bus.out_valid = (state == SCAN);
  assign bus.out_last  = (state == SCAN) && at_end;
  assign bus.out_row   = row;
  assign bus.out_col   = col;
  assign bus.out_win   = win;
endmodule

// File: tb/tb_window_scanner.sv
// Scoreboard bench for window_scanner: driver queues expected
// windows, a negedge monitor checks each accepted window.
module tb_window_scanner;
  localparam int CH = 32;
  localparam int H  = 5;
  localparam int W  = 6;
  localparam int K  = 3;
  localparam int DL = 8;
  localparam int OH = 3;
  localparam int OW = 4;
  localparam int RW = 2;
  localparam int CW = 2;
  localparam int MW = CH * H * W * DL;
  localparam int WW = CH * K * K * DL;
  localparam int NWIN = OH * OW;

  typedef struct {
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          last;
    logic [WW-1:0] win;
  } exp_t;

  typedef int nine_t [9];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  window_scanner_if #(
    .CH(CH), .H(H), .W(W), .K(K), .DL(DL)
  ) bus ();

  window_scanner #(
    .CH(CH), .H(H), .W(W), .K(K), .DL(DL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t exp_q [$];
  int tests = 0;
  int fails = 0;
  int hs_cnt = 0;
  logic [DL-1:0] mp [CH][H][W];

  function automatic logic [MW-1:0] pack_map();
    logic [MW-1:0] v;
    v = '0;
    for (int c = 0; c < CH; c++)
      for (int r = 0; r < H; r++)
        for (int x = 0; x < W; x++)
          v[((c*H*W + r*W + x)*DL) +: DL] = mp[c][r][x];
    return v;
  endfunction

  function automatic logic [WW-1:0] ref_win(int r, int cc);
    logic [WW-1:0] v;
    v = '0;
    for (int c = 0; c < CH; c++)
      for (int kr = 0; kr < K; kr++)
        for (int kc = 0; kc < K; kc++)
          v[((c*K*K + kr*K + kc)*DL) +: DL] = mp[c][r+kr][cc+kc];
    return v;
  endfunction

  task automatic push_scan();
    for (int r = 0; r < OH; r++)
      for (int cc = 0; cc < OW; cc++)
        exp_q.push_back('{row: RW'(r), col: CW'(cc),
                          last: (r == OH-1 && cc == OW-1),
                          win: ref_win(r, cc)});
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_win(string name, logic [WW-1:0] act, logic [WW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      for (int i = 0; i < CH*K*K; i++)
        if (act[i*DL +: DL] !== exp[i*DL +: DL]) begin
          $display("FAIL %s: element %0d got %0d, expected %0d",
                   name, i, act[i*DL +: DL], exp[i*DL +: DL]);
          break;
        end
    end
  endtask

  task automatic chk_chan(string name, int c, nine_t v);
    logic [DL-1:0] a;
    tests++;
    for (int i = 0; i < 9; i++) begin
      a = bus.out_win[((c*K*K + i)*DL) +: DL];
      if (a !== DL'(v[i])) begin
        fails++;
        $display("FAIL %s: ch %0d elem %0d got %0d, expected %0d",
                 name, c, i, a, v[i]);
        break;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(string name);
    for (int i = 0; i < 40; i++) begin
      if (bus.ready) break;
      step();
    end
    chk(name, 32'(bus.ready), 32'd1);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL extra_window: got row %0d col %0d, expected none",
                 bus.out_row, bus.out_col);
      end else begin
        e = exp_q.pop_front();
        chk("hs_row", 32'(bus.out_row), 32'(e.row));
        chk("hs_col", 32'(bus.out_col), 32'(e.col));
        chk("hs_last", 32'(bus.out_last), 32'(e.last));
        chk_win("hs_win", bus.out_win, e.win);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hs0;
    logic [WW-1:0] snap;
    bus.load = 1'b0;
    bus.d = '0;
    bus.out_ready = 1'b0;

    // 1: reset
    rst_n = 1'b0;
    step();
    step();
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_last", 32'(bus.out_last), 32'd0);
    chk_win("rst_win", bus.out_win, '0);
    rst_n = 1'b1;
    step();

    // 2: full scan, out_ready held high
    for (int c = 0; c < CH; c++)
      for (int r = 0; r < H; r++)
        for (int x = 0; x < W; x++)
          mp[c][r][x] = DL'(c*H*W + r*W + x);
    bus.d = pack_map();
    push_scan();
    bus.load = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.load = 1'b0;
    chk("t2_valid", 32'(bus.out_valid), 32'd1);
    chk("t2_busy", 32'(bus.ready), 32'd0);
    chk("t2_row0", 32'(bus.out_row), 32'd0);
    chk("t2_col0", 32'(bus.out_col), 32'd0);
    chk_chan("t2_ch0_00", 0, '{0, 1, 2, 6, 7, 8, 12, 13, 14});
    n = 1;
    for (int i = 0; i < 20 && !bus.out_last; i++) begin
      step();
      if (bus.out_valid) n++;
    end
    chk("t2_last", 32'(bus.out_last), 32'd1);
    chk("t2_count", 32'(n), 32'(NWIN));
    chk("t2_row_end", 32'(bus.out_row), 32'd2);
    chk("t2_col_end", 32'(bus.out_col), 32'd3);
    chk_chan("t2_ch0_23", 0, '{15, 16, 17, 21, 22, 23, 27, 28, 29});
    step();
    chk("t2_ready_after", 32'(bus.ready), 32'd1);
    chk("t2_valid_after", 32'(bus.out_valid), 32'd0);

    // 3: backpressure at (1,2)
    push_scan();
    hs0 = hs_cnt;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_row == 1 && bus.out_col == 2) break;
      step();
    end
    chk("t3_reach_row", 32'(bus.out_row), 32'd1);
    chk("t3_reach_col", 32'(bus.out_col), 32'd2);
    bus.out_ready = 1'b0;
    snap = bus.out_win;
    repeat (5) begin
      step();
      chk_win("t3_hold_win", bus.out_win, snap);
      chk("t3_hold_row", 32'(bus.out_row), 32'd1);
      chk("t3_hold_col", 32'(bus.out_col), 32'd2);
      chk("t3_hold_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    step();
    chk("t3_next_row", 32'(bus.out_row), 32'd1);
    chk("t3_next_col", 32'(bus.out_col), 32'd3);
    step();
    chk("t3_wrap_row", 32'(bus.out_row), 32'd2);
    chk("t3_wrap_col", 32'(bus.out_col), 32'd0);
    wait_idle("t3_idle");
    chk("t3_total", 32'(hs_cnt - hs0), 32'(NWIN));

    // 4: load during scan is ignored
    push_scan();
    hs0 = hs_cnt;
    bus.d = pack_map();
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    step();
    step();
    bus.d = ~pack_map();
    bus.load = 1'b1;
    step();
    chk("t4_busy", 32'(bus.ready), 32'd0);
    step();
    chk("t4_valid", 32'(bus.out_valid), 32'd1);
    bus.load = 1'b0;
    wait_idle("t4_idle");
    chk("t4_total", 32'(hs_cnt - hs0), 32'(NWIN));

    // 5: reset after 5th handshake
    bus.d = pack_map();
    push_scan();
    hs0 = hs_cnt;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (hs_cnt - hs0 >= 5) break;
      step();
    end
    chk("t5_hs5", 32'(hs_cnt - hs0), 32'd5);
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    exp_q.delete();
    step();
    chk("t5_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_ready", 32'(bus.ready), 32'd1);
    chk("t5_last", 32'(bus.out_last), 32'd0);
    chk_win("t5_win", bus.out_win, '0);
    rst_n = 1'b1;
    for (int c = 0; c < CH; c++)
      for (int r = 0; r < H; r++)
        for (int x = 0; x < W; x++)
          mp[c][r][x] = DL'((c*H*W + r*W + x)*3 + 1);
    bus.d = pack_map();
    push_scan();
    bus.out_ready = 1'b1;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    chk("t5_restart_valid", 32'(bus.out_valid), 32'd1);
    chk("t5_restart_row", 32'(bus.out_row), 32'd0);
    chk("t5_restart_col", 32'(bus.out_col), 32'd0);
    wait_idle("t5_idle");

    // 6: zero-padded all-ones interior
    for (int c = 0; c < CH; c++)
      for (int r = 0; r < H; r++)
        for (int x = 0; x < W; x++)
          mp[c][r][x] = (r >= 1 && r <= 3 && x >= 1 && x <= 4) ? 8'd1 : 8'd0;
    bus.d = pack_map();
    push_scan();
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    for (int c = 0; c < CH; c++)
      chk_chan("t6_corner", c, '{0, 0, 0, 0, 1, 1, 0, 1, 1});
    for (int i = 0; i < 20; i++) begin
      if (bus.out_row == 1 && bus.out_col == 1) break;
      step();
    end
    chk("t6_at_11", 32'({bus.out_row, bus.out_col}), 32'b0101);
    for (int c = 0; c < CH; c++)
      chk_chan("t6_inner", c, '{1, 1, 1, 1, 1, 1, 1, 1, 1});
    wait_idle("t6_idle");

    step();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
